// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one memory port.
// Data has priority over fetch, but a streak limit makes sure fetch is never starved.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int MAX_STREAK  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(MAX_STREAK + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [SW-1:0] streak;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic sel_d, lat_we, first, grant, grant_d, finish;
   always_comb begin
      grant     = state == IDLE && (i_req || d_req);
      grant_d   = d_req && (!i_req || streak != SW'(MAX_STREAK));
      finish    = state == BUSY && cnt == '0;
      state_nxt = grant ? BUSY : finish ? IDLE : state;
      busy      = state == BUSY;
      mem_addr  = busy ? lat_addr : '0;
      mem_wdata = busy ? lat_wdata : '0;
      mem_wr_en = busy && first && lat_we;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   // The write strobe is limited to the first BUSY cycle, so a store commits once however long the latency is.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt       <= '0;
         streak    <= '0;
         sel_d     <= 1'b0;
         lat_we    <= 1'b0;
         first     <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         i_done <= finish && !sel_d;
         d_done <= finish && sel_d;
         first  <= grant;
         if (grant) begin
            sel_d     <= grant_d;
            lat_addr  <= grant_d ? d_addr : i_addr;
            lat_we    <= grant_d && d_we;
            lat_wdata <= d_wdata;
            cnt       <= CW'(MEM_LATENCY - 1);
            streak    <= !(grant_d && i_req) ? '0 : streak == SW'(MAX_STREAK) ? streak : streak + 1'b1;
         end else if (busy && cnt != '0) cnt <= cnt - 1'b1;
         if (finish && !sel_d) i_rdata <= mem_rdata;
         if (finish && sel_d && !lat_we) d_rdata <= mem_rdata;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests for mem_port_arbiter at latency 1 and latency 3.
module tb_mem_port_arbiter;
   logic clk = 1'b0, reset = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic i_done, d_done, mem_wr_en, busy;
   logic i_req2 = 1'b0, d_req2 = 1'b0, d_we2 = 1'b0;
   logic [31:0] i_addr2 = '0, d_addr2 = '0, d_wdata2 = '0;
   logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
   logic i_done2, d_done2, mem_wr_en2, busy2;
   logic [31:0] mem [0:255];
   bit wr [0:255];
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.MEM_LATENCY(3)) dut2 (
      .clk(clk), .reset(reset), .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_done(i_done2),
      .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2), .d_rdata(d_rdata2), .d_done(d_done2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wr_en(mem_wr_en2), .mem_rdata(mem_rdata2), .busy(busy2));

   // Unwritten words read as C0DE_0000 | address; written words read back what was stored.
   assign mem_rdata  = wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : (32'hC0DE_0000 | mem_addr);
   assign mem_rdata2 = mem_addr2 ^ 32'h5A5A_5A5A;

   always @(posedge clk)
      if (mem_wr_en) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         wr[mem_addr[9:2]]  <= 1'b1;
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      tick;
      n_checks++;
      if ({busy, mem_wr_en, i_done, d_done, mem_addr, i_rdata, d_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b wr=%b idone=%b ddone=%b addr=%h, required all 0", busy, mem_wr_en, i_done, d_done, mem_addr);
      end
      reset = 1'b1;
      tick;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
      tick;
      n_checks++;
      if ({busy, mem_wr_en} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_pre_store: got busy=%b wr=%b, required 1 1", busy, mem_wr_en);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, mem_wr_en, i_done, d_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_abort: got busy=%b wr=%b idone=%b ddone=%b, required 0 0 0 0", busy, mem_wr_en, i_done, d_done);
      end
      d_req = 1'b0; d_we = 1'b0;
      #1 reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_checks++;
         if ({busy, i_done, d_done, mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_%0d: got busy=%b idone=%b ddone=%b addr=%h, required 0", c, busy, i_done, d_done, mem_addr);
         end
      end
      n_checks++;
      if (wr[16] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_write: got written=%b, required 0", wr[16]);
      end
   endtask

   task automatic test_fetch;
      i_addr = 32'h10; i_req = 1'b1;
      tick;
      n_checks++;
      if ({busy, i_done, mem_addr} !== {2'b10, 32'h10}) begin
         n_fail++;
         $display("FAIL fetch_busy: got busy=%b idone=%b addr=%h, required 1 0 00000010", busy, i_done, mem_addr);
      end
      tick;
      n_checks++;
      if ({busy, i_done, i_rdata} !== {2'b01, 32'hC0DE_0010}) begin
         n_fail++;
         $display("FAIL fetch_done: got busy=%b idone=%b rdata=%h, required 0 1 c0de0010", busy, i_done, i_rdata);
      end
      i_req = 1'b0;
      tick;
      n_checks++;
      if ({busy, i_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL fetch_pulse: got busy=%b idone=%b, required 0 0", busy, i_done);
      end
   endtask

   task automatic test_simultaneous;
      i_addr = 32'h10; i_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
      tick;
      n_checks++;
      if (mem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL sim_data_first: got addr=%h, required 00000200", mem_addr);
      end
      tick;
      n_checks++;
      if ({d_done, i_done, d_rdata} !== {2'b10, 32'hC0DE_0200}) begin
         n_fail++;
         $display("FAIL sim_data_done: got ddone=%b idone=%b rdata=%h, required 1 0 c0de0200", d_done, i_done, d_rdata);
      end
      d_req = 1'b0;
      tick;
      n_checks++;
      if ({busy, d_done, mem_addr} !== {2'b10, 32'h10}) begin
         n_fail++;
         $display("FAIL sim_fetch_busy: got busy=%b ddone=%b addr=%h, required 1 0 00000010", busy, d_done, mem_addr);
      end
      tick;
      n_checks++;
      if ({i_done, d_done, i_rdata} !== {2'b10, 32'hC0DE_0010}) begin
         n_fail++;
         $display("FAIL sim_fetch_done: got idone=%b ddone=%b rdata=%h, required 1 0 c0de0010", i_done, d_done, i_rdata);
      end
      i_req = 1'b0;
      tick;
   endtask

   task automatic test_starvation;
      logic [9:0] exp_d = 10'b01111_01111;
      i_addr = 32'h20; d_addr = 32'h204; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick;
         tick;
         n_checks++;
         if ({d_done, i_done} !== {exp_d[k], ~exp_d[k]}) begin
            n_fail++;
            $display("FAIL starve_grant_%0d: got ddone=%b idone=%b, required %b %b", k, d_done, i_done, exp_d[k], ~exp_d[k]);
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
   endtask

   task automatic test_store;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      tick;
      n_checks++;
      if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL store_strobe: got wr=%b addr=%h wdata=%h, required 1 00000100 deadbeef", mem_wr_en, mem_addr, mem_wdata);
      end
      tick;
      n_checks++;
      if ({mem_wr_en, d_done, d_rdata} !== {2'b01, 32'hC0DE_0204}) begin
         n_fail++;
         $display("FAIL store_done: got wr=%b ddone=%b rdata=%h, required 0 1 c0de0204", mem_wr_en, d_done, d_rdata);
      end
      d_req = 1'b0; d_we = 1'b0;
      tick;
      d_req = 1'b1;
      tick;
      n_checks++;
      if (mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL load_no_write: got wr=%b, required 0", mem_wr_en);
      end
      tick;
      n_checks++;
      if ({d_done, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL load_back: got ddone=%b rdata=%h, required 1 deadbeef", d_done, d_rdata);
      end
      d_req = 1'b0;
      tick;
   endtask

   task automatic test_latency3;
      logic [31:0] a;
      i_addr2 = 32'h30; i_req2 = 1'b1;
      for (int f = 0; f < 3; f++) begin
         a = 32'h30 + 32'(4 * f);
         for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++;
            if ({busy2, i_done2, mem_addr2} !== {2'b10, a}) begin
               n_fail++;
               $display("FAIL lat3_busy_%0d_%0d: got busy=%b idone=%b addr=%h, required 1 0 %h", f, c, busy2, i_done2, mem_addr2, a);
            end
         end
         tick;
         n_checks++;
         if ({busy2, i_done2, i_rdata2} !== {2'b01, a ^ 32'h5A5A_5A5A}) begin
            n_fail++;
            $display("FAIL lat3_done_%0d: got busy=%b idone=%b rdata=%h, required 0 1 %h", f, busy2, i_done2, i_rdata2, a ^ 32'h5A5A_5A5A);
         end
         i_addr2 = a + 32'h4;
      end
      i_req2 = 1'b0;
      tick;
      n_checks++;
      if ({busy2, i_done2} !== 2'b00) begin
         n_fail++;
         $display("FAIL lat3_idle: got busy=%b idone=%b, required 0 0", busy2, i_done2);
      end
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_simultaneous;
      test_starvation;
      test_store;
      test_latency3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
